// File: rtl/syscall_console_pkg.sv
// ----------------------------------------------------------------------------
// syscall_pkg
// Shared definitions for the syscall console unit: service codes, the FSM
// state encoding, the power-of-ten table used by the decimal converter and
// the ASCII bytes the unit emits on its own.
// ----------------------------------------------------------------------------
package syscall_pkg;

    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_EMIT,
        ST_NL,
        ST_CHAR,
        ST_DONE
    } state_t;

    // Element i holds 10^i.
    localparam logic [9:0][31:0] POW10_TABLE = {
        32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000,
        32'd100000,     32'd10000,     32'd1000,     32'd100,
        32'd10,         32'd1
    };

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        return (idx <= 4'd9) ? POW10_TABLE[idx] : 32'd0;
    endfunction

endpackage

// File: rtl/syscall_console_if.sv
// ----------------------------------------------------------------------------
// syscall_console_if
// Valid/ready byte stream from the syscall unit to the console transmitter.
//   tx_data  : ASCII byte (source -> sink)
//   tx_valid : byte available (source -> sink)
//   tx_ready : sink accepts the byte (sink -> source)
// ----------------------------------------------------------------------------
interface syscall_console_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/syscall_console_dec_digit_gen.sv
// ----------------------------------------------------------------------------
// dec_digit_gen
// Converts a 32-bit unsigned magnitude to decimal digits, most significant
// first, by repeated subtraction of powers of ten (one compare/subtract per
// cycle). Leading zeros are skipped; the units digit is always produced.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load i_mag and begin at 10^9
//   i_mag      : magnitude to convert
//   o_valid    : o_digit holds a digit to be emitted
//   o_digit    : current digit 0..9
//   o_last     : current digit is the units digit
//   i_ready    : consumer takes the digit this cycle
// ----------------------------------------------------------------------------
module dec_digit_gen
    import syscall_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_mag,
    output logic        o_valid,
    output logic [3:0]  o_digit,
    output logic        o_last,
    input  logic        i_ready
);

    logic [31:0] r_mag;
    logic [3:0]  r_idx;
    logic [3:0]  r_digit;
    logic        r_seen;    // a non-zero digit has already been emitted
    logic        r_active;
    logic        r_valid;

    logic [31:0] w_pow;
    logic        w_ge;

    assign w_pow = pow10(r_idx);
    assign w_ge  = (r_mag >= w_pow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag    <= 32'd0;
            r_idx    <= 4'd0;
            r_digit  <= 4'd0;
            r_seen   <= 1'b0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
        end else if (i_start) begin
            r_mag    <= i_mag;
            r_idx    <= 4'd9;
            r_digit  <= 4'd0;
            r_seen   <= 1'b0;
            r_active <= 1'b1;
            r_valid  <= 1'b0;
        end else if (r_active) begin
            if (r_valid) begin
                if (i_ready) begin
                    r_valid <= 1'b0;
                    r_seen  <= 1'b1;
                    r_digit <= 4'd0;
                    if (r_idx == 4'd0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_idx <= r_idx - 4'd1;
                    end
                end
            end else if (w_ge) begin
                r_mag   <= r_mag - w_pow;
                r_digit <= r_digit + 4'd1;
            end else if ((r_digit != 4'd0) || r_seen || (r_idx == 4'd0)) begin
                r_valid <= 1'b1;
            end else begin
                // Leading zero: drop it and move to the next power.
                r_idx <= r_idx - 4'd1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_digit = r_digit;
    assign o_last  = (r_idx == 4'd0);

endmodule

// File: rtl/syscall_console.sv
// ----------------------------------------------------------------------------
// syscall_console
// Syscall service unit for the single-cycle MIPS core: print integer (v0=1),
// print character (v0=11), exit (v0=10). Bytes leave over a valid/ready
// stream; the CPU is held through stall until the service finishes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   syscall    : current instruction is a syscall
//   v0, a0     : service code and argument from the register file
//   stall      : combinational PC/register-write hold
//   halted     : sticky, set by the exit service
//   bad_svc    : one-cycle pulse for an unsupported service code
//   tx         : byte stream (master side)
// ----------------------------------------------------------------------------
module syscall_console
    import syscall_pkg::*;
#(
    parameter int EMIT_NEWLINE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               syscall,
    input  logic [31:0]        v0,
    input  logic [31:0]        a0,
    output logic               stall,
    output logic               halted,
    output logic               bad_svc,
    syscall_console_if.master  tx
);

    state_t      r_state;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_halted;
    logic        r_bad_svc;
    logic        r_last;    // byte in the output register is the units digit

    logic        w_accept;
    logic        w_is_int;
    logic        w_is_char;
    logic        w_is_exit;
    logic [31:0] w_mag;
    logic        w_xfer;
    logic        w_gen_start;
    logic        w_gen_valid;
    logic [3:0]  w_gen_digit;
    logic        w_gen_last;
    logic        w_gen_ready;

    assign w_accept  = (r_state == ST_IDLE) && syscall && !r_halted;
    assign w_is_int  = (v0 == SVC_PRINT_INT);
    assign w_is_char = (v0 == SVC_PRINT_CHAR);
    assign w_is_exit = (v0 == SVC_EXIT);
    assign w_mag     = a0[31] ? (~a0 + 32'd1) : a0;
    assign w_xfer    = r_tx_valid && tx.tx_ready;

    // The converter starts at accept so it works while the sign byte waits.
    assign w_gen_start = w_accept && w_is_int;
    assign w_gen_ready = (r_state == ST_DIGIT);

    dec_digit_gen u_dec_digit_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_gen_start),
        .i_mag   (w_mag),
        .o_valid (w_gen_valid),
        .o_digit (w_gen_digit),
        .o_last  (w_gen_last),
        .i_ready (w_gen_ready)
    );

    // DONE drops stall so the PC advances while syscall is still high.
    assign stall = ((r_state != ST_IDLE) && (r_state != ST_DONE)) ||
                   (w_accept && (w_is_int || w_is_char));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_bad_svc  <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_bad_svc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_int) begin
                            if (a0[31]) begin
                                r_tx_data  <= ASCII_MINUS;
                                r_tx_valid <= 1'b1;
                                r_state    <= ST_SIGN;
                            end else begin
                                r_state <= ST_DIGIT;
                            end
                        end else if (w_is_char) begin
                            r_tx_data  <= a0[7:0];
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_CHAR;
                        end else if (w_is_exit) begin
                            r_halted <= 1'b1;
                        end else begin
                            r_bad_svc <= 1'b1;
                        end
                    end
                end
                ST_SIGN: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (w_gen_valid) begin
                        r_tx_data  <= ASCII_ZERO + {4'd0, w_gen_digit};
                        r_tx_valid <= 1'b1;
                        r_last     <= w_gen_last;
                        r_state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        if (!r_last) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_DIGIT;
                        end else if (EMIT_NEWLINE != 0) begin
                            // Newline goes straight into the output register.
                            r_tx_data <= ASCII_LF;
                            r_state   <= ST_NL;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_NL, ST_CHAR: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign halted      = r_halted;
    assign bad_svc     = r_bad_svc;

endmodule

// File: tb/tb_syscall_console.sv
module tb_syscall_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall1 = 1'b0;
    logic [31:0] v0_1 = 32'd0;
    logic [31:0] a0_1 = 32'd0;
    logic        syscall2 = 1'b0;
    logic [31:0] v0_2 = 32'd0;
    logic [31:0] a0_2 = 32'd0;
    logic        stall1, halted1, bad1;
    logic        stall2, halted2, bad2;

    int total = 0;
    int bad = 0;

    logic [7:0] got1[$];
    logic [7:0] got2[$];

    syscall_console_if u_if1();
    syscall_console_if u_if2();

    assign u_if2.tx_ready = 1'b1;

    syscall_console #(.EMIT_NEWLINE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .syscall(syscall1), .v0(v0_1), .a0(a0_1),
        .stall(stall1), .halted(halted1), .bad_svc(bad1), .tx(u_if1)
    );

    syscall_console #(.EMIT_NEWLINE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .syscall(syscall2), .v0(v0_2), .a0(a0_2),
        .stall(stall2), .halted(halted2), .bad_svc(bad2), .tx(u_if2)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so a valid&&ready seen here transfers
    // at the following rising edge.
    always @(negedge clk) begin
        if (u_if1.tx_valid && u_if1.tx_ready) got1.push_back(u_if1.tx_data);
        if (u_if2.tx_valid && u_if2.tx_ready) got2.push_back(u_if2.tx_data);
    end

    // Issue a print service and hold syscall until stall drops (DONE),
    // keeping syscall high through that DONE cycle.
    task automatic run_svc(input bit which, input logic [31:0] v, input logic [31:0] a,
                           output bit timed_out);
        @(posedge clk); #1;
        if (which) begin syscall2 = 1'b1; v0_2 = v; a0_2 = a; end
        else       begin syscall1 = 1'b1; v0_1 = v; a0_1 = a; end
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!(which ? stall2 : stall1)) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        if (which) syscall2 = 1'b0; else syscall1 = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall1); end
        total++; if (u_if1.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", u_if1.tx_valid); end
        total++; if (u_if1.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", u_if1.tx_data); end
        total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted1); end
        total++; if (bad1 !== 1'b0) begin bad++; $display("FAIL reset_bad_svc got=%b exp=0", bad1); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        $display("test_reset: checked reset outputs");
    endtask

    task automatic test_print_zero;
        bit to;
        got1.delete();
        run_svc(1'b0, 32'd1, 32'd0, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL zero_timeout got=%b exp=0", to); end
        @(negedge clk);
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL zero_retrigger_stall got=%b exp=0", stall1); end
        repeat (3) @(negedge clk);
        total++; if (got1.size() !== 1) begin bad++; $display("FAIL zero_count got=%0d exp=1", got1.size()); end
        else begin
            total++; if (got1[0] !== 8'h30) begin bad++; $display("FAIL zero_byte got=%h exp=30", got1[0]); end
        end
        $display("test_print_zero: %0d bytes", got1.size());
    endtask

    task automatic test_print_string(input bit which, input logic [31:0] a, input string exp, input string name);
        bit to;
        logic [7:0] eb;
        if (which) got2.delete(); else got1.delete();
        run_svc(which, 32'd1, a, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout got=%b exp=0", name, to); end
        repeat (3) @(negedge clk);
        total++;
        if ((which ? got2.size() : got1.size()) !== exp.len()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", name, which ? got2.size() : got1.size(), exp.len());
        end else begin
            for (int i = 0; i < exp.len(); i++) begin
                eb = exp[i];
                total++;
                if ((which ? got2[i] : got1[i]) !== eb) begin
                    bad++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, which ? got2[i] : got1[i], eb);
                end
            end
        end
        $display("%s: a0=%h expected \"%s\"", name, a, exp);
    endtask

    task automatic test_char_backpressure;
        got1.delete();
        @(posedge clk); #1;
        u_if1.tx_ready = 1'b0; syscall1 = 1'b1; v0_1 = 32'd11; a0_1 = 32'h00001241;
        @(negedge clk);
        total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL char_accept_stall got=%b exp=1", stall1); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (u_if1.tx_valid !== 1'b1) begin bad++; $display("FAIL char_hold_valid%0d got=%b exp=1", k, u_if1.tx_valid); end
            total++; if (u_if1.tx_data !== 8'h41) begin bad++; $display("FAIL char_hold_data%0d got=%h exp=41", k, u_if1.tx_data); end
            total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL char_hold_stall%0d got=%b exp=1", k, stall1); end
        end
        @(posedge clk); #1; u_if1.tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL char_done_stall got=%b exp=0", stall1); end
        @(posedge clk); #1; syscall1 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (got1.size() !== 1) begin bad++; $display("FAIL char_count got=%0d exp=1", got1.size()); end
        else begin
            total++; if (got1[0] !== 8'h41) begin bad++; $display("FAIL char_byte got=%h exp=41", got1[0]); end
        end
        $display("test_char_backpressure: %0d transfers", got1.size());
    endtask

    task automatic test_bad_svc;
        got1.delete();
        @(posedge clk); #1; syscall1 = 1'b1; v0_1 = 32'd5; a0_1 = 32'd0;
        @(negedge clk);
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL bad_svc_stall got=%b exp=0", stall1); end
        total++; if (bad1 !== 1'b0) begin bad++; $display("FAIL bad_svc_early got=%b exp=0", bad1); end
        @(posedge clk); #1; syscall1 = 1'b0;
        @(negedge clk);
        total++; if (bad1 !== 1'b1) begin bad++; $display("FAIL bad_svc_pulse got=%b exp=1", bad1); end
        @(negedge clk);
        total++; if (bad1 !== 1'b0) begin bad++; $display("FAIL bad_svc_width got=%b exp=0", bad1); end
        repeat (2) @(negedge clk);
        total++; if (got1.size() !== 0) begin bad++; $display("FAIL bad_svc_bytes got=%0d exp=0", got1.size()); end
        $display("test_bad_svc: v0=5 done");
    endtask

    task automatic test_exit;
        got1.delete();
        @(posedge clk); #1; syscall1 = 1'b1; v0_1 = 32'd10; a0_1 = 32'd0;
        @(negedge clk);
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL exit_stall got=%b exp=0", stall1); end
        total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL exit_halted_early got=%b exp=0", halted1); end
        @(posedge clk); #1; syscall1 = 1'b0;
        @(negedge clk);
        total++; if (halted1 !== 1'b1) begin bad++; $display("FAIL exit_halted got=%b exp=1", halted1); end
        @(posedge clk); #1; syscall1 = 1'b1; v0_1 = 32'd11; a0_1 = 32'h33;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL exit_ignored_stall%0d got=%b exp=0", k, stall1); end
        end
        @(posedge clk); #1; syscall1 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (got1.size() !== 0) begin bad++; $display("FAIL exit_bytes got=%0d exp=0", got1.size()); end
        total++; if (halted1 !== 1'b1) begin bad++; $display("FAIL exit_sticky got=%b exp=1", halted1); end
        @(posedge clk); #3; rst_n = 1'b0;
        #2;
        total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL exit_reset_halted got=%b exp=0", halted1); end
        @(negedge clk); rst_n = 1'b1;
        $display("test_exit: halted then cleared by reset");
    endtask

    task automatic test_reset_mid;
        bit to;
        @(posedge clk); #1; syscall1 = 1'b1; v0_1 = 32'd1; a0_1 = 32'h7FFFFFFF;
        repeat (20) @(posedge clk);
        #2;
        total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL mid_busy_stall got=%b exp=1", stall1); end
        #1; syscall1 = 1'b0; rst_n = 1'b0;
        #1;
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", stall1); end
        total++; if (u_if1.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got=%b exp=0", u_if1.tx_valid); end
        total++; if (u_if1.tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got=%h exp=00", u_if1.tx_data); end
        total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL mid_halted got=%b exp=0", halted1); end
        total++; if (bad1 !== 1'b0) begin bad++; $display("FAIL mid_bad_svc got=%b exp=0", bad1); end
        @(negedge clk); rst_n = 1'b1;
        got1.delete();
        run_svc(1'b0, 32'd11, 32'h5A, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL mid_after_timeout got=%b exp=0", to); end
        repeat (3) @(negedge clk);
        total++; if (got1.size() !== 1) begin bad++; $display("FAIL mid_after_count got=%0d exp=1", got1.size()); end
        else begin
            total++; if (got1[0] !== 8'h5A) begin bad++; $display("FAIL mid_after_byte got=%h exp=5a", got1[0]); end
        end
        $display("test_reset_mid: %0d bytes after reset", got1.size());
    endtask

    initial begin
        u_if1.tx_ready = 1'b1;
        test_reset();
        test_print_zero();
        test_print_string(1'b0, 32'hFFFFFF85, "-123", "neg123");
        test_print_string(1'b1, 32'hFFFFFF85, "-123\n", "neg123_nl");
        test_print_string(1'b0, 32'h80000000, "-2147483648", "int_min");
        test_print_string(1'b0, 32'h7FFFFFFF, "2147483647", "int_max");
        test_print_string(1'b0, 32'd1000000000, "1000000000", "inner_zeros");
        test_char_backpressure();
        test_bad_svc();
        test_exit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
